// File: rtl/video_sync_decoder.sv
// Recovers pixel position and colour from a hsync/vsync/RGB stream, tracks line timing
// and reports lock, visible-area pixels, frame starts and lock losses with a fixed 2-cycle latency.
module video_sync_decoder #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        locked,
  output logic        visible,
  output logic [9:0]  position_x,
  output logic [8:0]  position_y,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start,
  output logic [15:0] frame,
  output logic [7:0]  err_count
);

  localparam int WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_HS     = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] X_LAST   = 10'(WHOLE_LINE - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VS     = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] Y_LAST   = 10'(WHOLE_FRAME - 1);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] PER_GOOD = 10'(WHOLE_LINE - 1);
  localparam logic [9:0] PER_TMO  = 10'(WHOLE_LINE);
  localparam logic [7:0] LOCK_MIN = 8'(LOCK_LINES);

  typedef enum logic [1:0] {UNLOCKED, TRACKING, LOCKED} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic       hs_p0, vs_p0, hs_dly, vs_dly, vld_p0, vld_dly;
  logic [3:0] r_p0, g_p0, b_p0;

  state_t     state;
  logic [9:0] x_p1, y_p1, per_p1;
  logic [7:0] good_p1, err_p1;
  logic [3:0] r_p1, g_p1, b_p1;

  logic       hs_fall, vs_fall, x_wrap, line_good, loss;
  logic [9:0] x_nxt, y_nxt;
  logic       lk_p1, vis_p1, fs_p1;

  // Stage p0: pin registers plus one delayed copy of the syncs for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0   <= 1'b1;
      vs_p0   <= 1'b1;
      hs_dly  <= 1'b1;
      vs_dly  <= 1'b1;
      vld_p0  <= 1'b0;
      vld_dly <= 1'b0;
      r_p0    <= '0;
      g_p0    <= '0;
      b_p0    <= '0;
    end else begin
      hs_p0   <= hsync;
      vs_p0   <= vsync;
      hs_dly  <= hs_p0;
      vs_dly  <= vs_p0;
      vld_p0  <= 1'b1;
      vld_dly <= vld_p0;
      r_p0    <= r_in;
      g_p0    <= g_in;
      b_p0    <= b_in;
    end
  end

  // History is only trusted once it holds a real sample, so a sync held low through reset is no edge
  always_comb begin
    hs_fall   = vld_dly & hs_dly & ~hs_p0;
    vs_fall   = vld_dly & vs_dly & ~vs_p0;
    x_wrap    = (x_p1 == X_LAST);
    x_nxt     = x_wrap ? 10'd0 : x_p1 + 10'd1;
    y_nxt     = y_p1;
    if (x_wrap)
      y_nxt = (y_p1 == Y_LAST) ? 10'd0 : y_p1 + 10'd1;
    line_good = (per_p1 == PER_GOOD);
    loss      = (state == LOCKED) &&
                ((hs_fall && !line_good) ||
                 (!hs_fall && (per_p1 == PER_TMO)) ||
                 (vs_fall && !((x_nxt == 10'd0) && (y_nxt == Y_VS))));
  end

  // Stage p1: position tracking, line period measurement and lock state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      x_p1    <= '0;
      y_p1    <= '0;
      per_p1  <= '0;
      good_p1 <= '0;
      err_p1  <= '0;
      r_p1    <= '0;
      g_p1    <= '0;
      b_p1    <= '0;
    end else begin
      r_p1   <= r_p0;
      g_p1   <= g_p0;
      b_p1   <= b_p0;
      per_p1 <= hs_fall ? 10'd0 : sat_inc10(per_p1);
      if (vs_fall) begin
        x_p1 <= 10'd0;
        y_p1 <= Y_VS;
      end else begin
        x_p1 <= hs_fall ? X_HS : x_nxt;
        y_p1 <= y_nxt;
      end
      case (state)
        UNLOCKED: begin
          if (hs_fall) begin
            state   <= TRACKING;
            good_p1 <= '0;
          end
        end
        TRACKING: begin
          if (hs_fall)
            good_p1 <= line_good ? sat_inc8(good_p1) : 8'd0;
          if (vs_fall && (good_p1 >= LOCK_MIN))
            state <= LOCKED;
        end
        LOCKED: begin
          if (loss) begin
            state  <= UNLOCKED;
            err_p1 <= sat_inc8(err_p1);
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  always_comb begin
    lk_p1  = (state == LOCKED);
    vis_p1 = lk_p1 && (x_p1 < X_VIS) && (y_p1 < Y_VIS);
    fs_p1  = lk_p1 && (x_p1 == 10'd0) && (y_p1 == 10'd0);
  end

  // Stage p2: registered outputs, blanked whenever timing is not locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked      <= 1'b0;
      visible     <= 1'b0;
      position_x  <= '0;
      position_y  <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      frame_start <= 1'b0;
      frame       <= '0;
      err_count   <= '0;
    end else begin
      locked      <= lk_p1;
      visible     <= vis_p1;
      position_x  <= lk_p1 ? x_p1 : 10'd0;
      position_y  <= lk_p1 ? y_p1[8:0] : 9'd0;
      r           <= vis_p1 ? r_p1 : 4'd0;
      g           <= vis_p1 ? g_p1 : 4'd0;
      b           <= vis_p1 ? b_p1 : 4'd0;
      frame_start <= fs_p1;
      if (fs_p1)
        frame <= frame + 16'd1;
      err_count   <= err_p1;
    end
  end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder using a reduced 32x20 timing so whole frames stay short.
module tb_video_sync_decoder;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 4;
  localparam int LL = 4;
  localparam int WL = HV + HF + HS + HB;
  localparam int WF = VV + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        locked, visible, frame_start;
  logic [9:0]  position_x;
  logic [8:0]  position_y;
  logic [3:0]  r, g, b;
  logic [15:0] frame;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_miss = 0;
  int gx, gy;
  bit hold_pos = 0, hs_high = 0, vs_low = 0;
  int hx[4], hy[4], hr[4], hg[4], hb[4];
  int bad, fr0;

  video_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .locked(locked), .visible(visible),
    .position_x(position_x), .position_y(position_y),
    .r(r), .g(g), .b(b),
    .frame_start(frame_start), .frame(frame), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One pixel of the timing generator; hx/hy[3] is the pixel now on the outputs
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) begin
      hx[k] = hx[k-1]; hy[k] = hy[k-1];
      hr[k] = hr[k-1]; hg[k] = hg[k-1]; hb[k] = hb[k-1];
    end
    hx[0] = gx;
    hy[0] = gy;
    hr[0] = ((gx == 0 && gy == 0) || (gx == HV + 1 && gy == 3)) ? 15 : (gx % 16);
    hg[0] = gy % 16;
    hb[0] = 15 - (gx % 16);
    hsync = hs_high ? 1'b1 : !(gx >= HV + HF && gx < HV + HF + HS);
    vsync = vs_low ? 1'b0 : !(gy >= VV + VF && gy < VV + VF + VS);
    r_in  = 4'(hr[0]);
    g_in  = 4'(hg[0]);
    b_in  = 4'(hb[0]);
    if (hold_pos) hold_pos = 0;
    else begin
      gx++;
      if (gx == WL) begin
        gx = 0;
        gy = (gy + 1) % WF;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int x, input int y, input string tag);
    int n = 0;
    while (!(hx[3] == x && hy[3] == y) && n < 2000) begin
      tick();
      n++;
    end
    if (!(hx[3] == x && hy[3] == y)) check({tag, "_reach_x"}, hx[3], x);
  endtask

  task automatic gen_to(input int x, input int y, input string tag);
    int n = 0;
    while (!(gx == x && gy == y) && n < 2000) begin
      tick();
      n++;
    end
    if (!(gx == x && gy == y)) check({tag, "_gen_x"}, gx, x);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      hx[k] = 0; hy[k] = 0; hr[k] = 0; hg[k] = 0; hb[k] = 0;
    end
    gx = HV + HF + HS;
    gy = VV + VF + VS;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_visible", visible, 0);
    check("rst_x", position_x, 0);
    check("rst_y", position_y, 0);
    check("rst_fs", frame_start, 0);
    check("rst_frame", frame, 0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;

    // Acquire lock at the first vsync; nothing may show before it
    bad = 0;
    for (int n = 0; n < 2000 && !(hx[3] == 0 && hy[3] == VV + VF); n++) begin
      tick();
      if (!(hx[3] == 0 && hy[3] == VV + VF))
        if (locked || visible || position_x != 0 || position_y != 0 || frame_start) bad++;
    end
    check("prelock_quiet", bad, 0);
    check("lock_at_vs", locked, 1);
    check("lock_x", position_x, 0);
    check("lock_y", position_y, VV + VF);

    // Track a full frame pixel by pixel
    bad = 0;
    for (int n = 0; n < 700; n++) begin
      int vis_e;
      tick();
      vis_e = (hx[3] < HV && hy[3] < VV) ? 1 : 0;
      if (locked != 1'b1) bad++;
      if (int'(position_x) != hx[3]) bad++;
      if (int'(position_y) != hy[3]) bad++;
      if (int'(visible) != vis_e) bad++;
      if (int'(frame_start) != ((hx[3] == 0 && hy[3] == 0) ? 1 : 0)) bad++;
      if (int'(r) != (vis_e != 0 ? hr[3] : 0)) bad++;
      if (int'(g) != (vis_e != 0 ? hg[3] : 0)) bad++;
      if (int'(b) != (vis_e != 0 ? hb[3] : 0)) bad++;
      if (hx[3] == 0 && hy[3] == 0) begin
        check("origin_r", r, 15);
        check("origin_fs", frame_start, 1);
        check("origin_frame", frame, 1);
      end
      if (hx[3] == HV + 1 && hy[3] == 3) check("blank_r", r, 0);
    end
    check("track_frame", bad, 0);

    // One line stretched by a cycle
    gen_to(0, 5, "stretch");
    hold_pos = 1;
    run_to(HV + HF - 1, 5, "stretch");
    check("stretch_pre_lock", locked, 1);
    tick();
    check("stretch_unlock", locked, 0);
    check("stretch_err", err_count, 1);
    run_to(0, VV + VF, "relock1");
    check("relock1_lock", locked, 1);
    check("relock1_err", err_count, 1);

    // Missing hsync pulse: period times out
    gen_to(0, 2, "tmo");
    hs_high = 1;
    run_to(HV + HF, 2, "tmo");
    check("tmo_pre_lock", locked, 1);
    tick();
    check("tmo_unlock", locked, 0);
    check("tmo_err", err_count, 2);
    bad = 0;
    for (int n = 0; n < 100 && !(gx == 8 && gy == 3); n++) begin
      tick();
      if (visible || locked) bad++;
    end
    hs_high = 0;
    check("tmo_no_visible", bad, 0);
    run_to(0, VV + VF, "relock2");
    check("relock2_lock", locked, 1);
    check("relock2_err", err_count, 2);

    // Spurious vsync mid-frame
    gen_to(0, 6, "vsinj");
    vs_low = 1;
    tick();
    tick();
    vs_low = 0;
    run_to(WL - 1, 5, "vsinj");
    check("vsinj_pre_lock", locked, 1);
    fr0 = frame;
    tick();
    check("vsinj_unlock", locked, 0);
    check("vsinj_err", err_count, 3);
    check("vsinj_frame", frame, fr0);
    run_to(0, 10, "vsinj_hold");
    check("vsinj_frame_hold", frame, fr0);
    run_to(0, VV + VF, "relock3");
    check("relock3_lock", locked, 1);

    // Asynchronous reset mid-frame
    run_to(5, 4, "arst");
    check("arst_pre_vis", visible, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_visible", visible, 0);
    check("arst_x", position_x, 0);
    check("arst_y", position_y, 0);
    check("arst_frame", frame, 0);
    check("arst_err", err_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    run_to(0, VV + VF, "arst_relock");
    check("arst_relock_lock", locked, 1);
    check("arst_relock_err", err_count, 0);
    run_to(0, 0, "arst_origin");
    check("arst_origin_fs", frame_start, 1);
    check("arst_origin_frame", frame, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse width.
- H_BACK, 48, horizontal back porch.
- V_VISIBLE, 480, active lines.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch.
- LOCK_LINES, 4, good lines required before lock.
REQ-002 Ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
- clk, in, 1, pixel clock.
- rst_n, in, 1, async active-low reset.
- hsync, in, 1, active-low line sync.
- vsync, in, 1, active-low frame sync.
- r_in, g_in, b_in, in, 4 each, pixel colour.
- locked, out, 1, timing lock.
- visible, out, 1, output pixel is active.
- position_x, out, 10, column of the output pixel.
- position_y, out, 9, row of the output pixel.
- r, g, b, out, 4 each, recovered pixel.
- frame_start, out, 1, one-cycle pulse at the output pixel (0,0).
- frame, out, 16, locked-frame count.
- err_count, out, 8, lock losses, saturating.

Function
REQ-003 WHOLE_LINE = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); WHOLE_FRAME = V totals summed (525).
REQ-004 All pin inputs pass through one register stage. Edge detection uses that stage and one delayed copy.
REQ-005 Fixed latency of 2 cycles: the pin sample taken at edge N appears on r/g/b/position/visible at edge N+2.
REQ-006 Horizontal alignment: the first low hsync sample is position_x = H_VISIBLE+H_FRONT (656).
- Otherwise x increments each cycle, wrapping WHOLE_LINE-1 to 0.
REQ-007 Vertical alignment: the first low vsync sample is position_y = V_VISIBLE+V_FRONT (490), x = 0.
- Otherwise y increments when x wraps, with y wrapping WHOLE_FRAME-1 to 0.
REQ-008 Line period counter: 10-bit, restarts at each hsync falling edge, saturates at 1023.
REQ-009 A line is good when the period between consecutive hsync falling edges is exactly WHOLE_LINE.
REQ-010 Lock FSM states: UNLOCKED, TRACKING, LOCKED. The locked output = (state==LOCKED), aligned to the output pipeline.
REQ-011 UNLOCKED -> TRACKING on the first hsync falling edge; good-line counter cleared.
REQ-012 TRACKING behaviour:
- Good line: increment the good-line counter, saturating at 255.
- Bad line: clear the counter and stay in TRACKING.
- Vsync falling edge with counter >= LOCK_LINES: go to LOCKED and load y=490.
- Vsync falling edge with counter < LOCK_LINES: ignored.
REQ-013 LOCKED -> UNLOCKED, with err_count+1 (saturating at 255), on any of:
- a hsync falling edge whose period is not WHOLE_LINE;
- the period counter reaching WHOLE_LINE+1 without a falling edge (timeout);
- a vsync falling edge whose tracked position is not x=0, y=490.
REQ-014 Simultaneous events: a loss condition takes priority over any lock or count update in the same cycle.
REQ-015 visible = locked && position_x < H_VISIBLE && position_y < V_VISIBLE.
- r/g/b = delayed input when visible, else 0.
REQ-016 frame_start pulses for exactly one cycle when locked and the output position is (0,0).
- frame increments in that same cycle, wrapping at 16 bits.
REQ-017 When not locked: position_x and position_y are 0, visible is 0, frame_start is 0, and frame holds its value.

Reset
REQ-018 rst_n low asynchronously clears:
- state to UNLOCKED;
- all counters, pipeline registers and edge history;
- all outputs to 0, including frame and err_count.
REQ-019 Edge history resets to the "high" level, so a sync held low through reset release is not seen as a falling edge.
REQ-020 Reset asserted mid-frame forces outputs to 0 immediately (no clock needed). Relock follows REQ-011/012.

Verification
REQ-021 Driver is a 640x480 timing generator released from reset at x=752, y=492 -> the first vsync low sample appears at the outputs with locked=1, x=0, y=490. Every later output position equals the generator position 2 cycles earlier.
REQ-022 While locked, stretch one line to 801 cycles -> locked=0 when that hsync edge reaches the outputs; err_count=1; relock at the next valid vsync.
REQ-023 While locked, hold hsync high for 900 cycles -> locked drops when the period reaches 801; err_count increments; visible=0 afterwards.
REQ-024 While locked, inject a vsync falling edge at y=300 -> immediate unlock; err_count+1; frame unchanged.
REQ-025 Drive r_in=0xF at generator pixel (0,0) and at (700,10) -> output r=0xF at (0,0) with frame_start=1 and frame+1; output r=0 at (700,10).
REQ-026 Pulse rst_n low mid-frame for 3 cycles -> all outputs 0 asynchronously; locked returns after the next valid vsync with LOCK_LINES good lines seen.
